sum_ctrl_unit: RTL

- FSM control unit for the dedicated accumulate processor datapath.
- Consumes the datapath status `lt` (counter < limit) and produces every datapath control strobe: counter path MuxSel/En, accumulator path MuxSel_2/En_2, and output tri-state enable OutBuf.
- Adds a start/busy/done handshake toward the host, plus an iteration watchdog that stops runaway loops.

---
 rtl/sum_ctrl_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sum_ctrl_unit.sv
// sum_ctrl_unit
// Control FSM for the accumulate datapath (sum of 0..limit-1). Sequences the
// counter and accumulator load strobes and the output tri-state buffer from
// the datapath comparator status, with a start/busy/done host handshake and
// an iteration watchdog that parks the unit in FAULT on runaway loops.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   run request, honoured only in IDLE and FAULT
//   lt       in   datapath comparator (counter < limit), used only in CMP
//   MuxSel   out  counter mux select (0: load 0, 1: counter+1)
//   En       out  counter load enable
//   MuxSel_2 out  accumulator mux select (0: load 0, 1: acc+counter)
//   En_2     out  accumulator load enable
//   OutBuf   out  enables the datapath output driver
//   busy     out  high in INIT, CMP, SUM, INC, OUT
//   done     out  one-cycle completion pulse
//   timeout  out  high while in FAULT
module sum_ctrl_unit #(
  parameter int MAX_ITER = 255,
  parameter int OUT_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic lt,
  output logic MuxSel,
  output logic En,
  output logic MuxSel_2,
  output logic En_2,
  output logic OutBuf,
  output logic busy,
  output logic done,
  output logic timeout
);

  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam int HOLD_W = $clog2(OUT_HOLD + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_SUM   = 3'd3;
  localparam logic [2:0] S_INC   = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_FAULT = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Outputs are flopped copies of the decode of the next state, so each
  // output changes on the same edge as the state it belongs to.
  logic mux_sel_q, mux_sel_d;
  logic en_q, en_d;
  logic mux_sel2_q, mux_sel2_d;
  logic en2_q, en2_d;
  logic out_buf_q, out_buf_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic timeout_q, timeout_d;

  // Next-state and counter update logic.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
        else       state_d = S_IDLE;
      end
      S_INIT: begin
        iter_cnt_d = {ITER_W{1'b0}};
        hold_cnt_d = {HOLD_W{1'b0}};
        state_d    = S_CMP;
      end
      S_CMP: begin
        if (lt) begin
          state_d = S_SUM;
        end else begin
          state_d    = S_OUT;
          hold_cnt_d = {HOLD_W{1'b0}};
        end
      end
      S_SUM: begin
        state_d = S_INC;
      end
      S_INC: begin
        iter_cnt_d = iter_cnt_q + ITER_W'(1);
        // Watchdog: the pass that reaches MAX_ITER goes to FAULT, so the
        // iteration counter can never wrap.
        if (iter_cnt_q + ITER_W'(1) == ITER_W'(MAX_ITER)) state_d = S_FAULT;
        else                                              state_d = S_CMP;
      end
      S_OUT: begin
        if (hold_cnt_q == HOLD_W'(OUT_HOLD - 1)) begin
          state_d = S_DONE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (start) state_d = S_INIT;
        else       state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore decode of the upcoming state into the output flop inputs.
  always_comb begin
    mux_sel_d  = 1'b0;
    en_d       = 1'b0;
    mux_sel2_d = 1'b0;
    en2_d      = 1'b0;
    out_buf_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    case (state_d)
      S_INIT: begin
        en_d   = 1'b1;
        en2_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_CMP: begin
        busy_d = 1'b1;
      end
      S_SUM: begin
        mux_sel2_d = 1'b1;
        en2_d      = 1'b1;
        busy_d     = 1'b1;
      end
      S_INC: begin
        mux_sel_d = 1'b1;
        en_d      = 1'b1;
        busy_d    = 1'b1;
      end
      S_OUT: begin
        out_buf_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      S_FAULT: begin
        timeout_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iter_cnt_q <= {ITER_W{1'b0}};
      hold_cnt_q <= {HOLD_W{1'b0}};
      mux_sel_q  <= 1'b0;
      en_q       <= 1'b0;
      mux_sel2_q <= 1'b0;
      en2_q      <= 1'b0;
      out_buf_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      mux_sel_q  <= mux_sel_d;
      en_q       <= en_d;
      mux_sel2_q <= mux_sel2_d;
      en2_q      <= en2_d;
      out_buf_q  <= out_buf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign MuxSel   = mux_sel_q;
  assign En       = en_q;
  assign MuxSel_2 = mux_sel2_q;
  assign En_2     = en2_q;
  assign OutBuf   = out_buf_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;

endmodule
